// File: rtl/int_ctrl_pkg.sv
// databus: shared register offsets, state type and address decode for int_ctrl
// Contents:
//   ICTRL_PENDING/MASK/MODE/CLAIM  word offsets inside the 16-byte window
//   ICTRL_NONE                     value read from CLAIM when nothing can be claimed
//   ICTRL_STATE                    claim/complete handshake state
//   ictrl_hit                      true for a word-aligned address inside the window
package databus;

    localparam logic [3:0] ICTRL_PENDING = 4'h0;
    localparam logic [3:0] ICTRL_MASK    = 4'h4;
    localparam logic [3:0] ICTRL_MODE    = 4'h8;
    localparam logic [3:0] ICTRL_CLAIM   = 4'hC;

    localparam logic [31:0] ICTRL_NONE = 32'hFFFF_FFFF;

    typedef enum logic {
        ICTRL_IDLE,
        ICTRL_CLAIMED
    } ICTRL_STATE;

    function automatic logic ictrl_hit(input logic [31:0] a, input logic [31:0] base);
        return (a[31:4] == base[31:4]) && (a[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/int_ctrl_prio.sv
// int_ctrl_prio: combinational lowest-index-first priority encoder
// Ports:
//   req    in   N  request vector (already masked)
//   valid  out  1  at least one request set
//   id     out  4  index of the lowest set request, 0 when none
module int_ctrl_prio #(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [3:0]   id
);

    // Scanning downwards lets the lowest set index overwrite the higher ones.
    always_comb begin
        valid = 1'b0;
        id    = 4'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                id    = 4'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: memory-mapped interrupt controller folding NUM_SRC sources onto HWInt[OUT_LINE]
// Build option: define INT_CTRL_EDGE_EN for per-source edge-triggered mode (MODE register + irq_q flops).
// Ports:
//   clk     in   1        system clock
//   reset   in   1        synchronous reset, active high
//   irq_i   in   NUM_SRC  source requests
//   hw_in   in   6        pass-through HWInt sources, bit OUT_LINE ignored
//   addr    in   32       DM-bus byte address
//   byteen  in   4        write byte enables, only 4'b1111 writes
//   wdata   in   32       write data
//   rd_en   in   1        load strobe, qualifies the claim side effect
//   rdata   out  32       combinational read data
//   HWInt   out  6        registered interrupt lines to the CPU
module int_ctrl
    import databus::*;
#(
    parameter int          NUM_SRC  = 8,
    parameter logic [31:0] BASE     = 32'h0000_7F40,
    parameter int          OUT_LINE = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_i,
    input  logic [5:0]         hw_in,
    input  logic [31:0]        addr,
    input  logic [3:0]         byteen,
    input  logic [31:0]        wdata,
    input  logic               rd_en,
    output logic [31:0]        rdata,
    output logic [5:0]         HWInt
);

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] pending_next;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] mode;
    ICTRL_STATE         state;
    logic [3:0]         claim_id;
    logic               hit;
    logic [3:0]         off;
    logic               full;
    logic               win_valid;
    logic [3:0]         win_id;
    logic               claim_at;
    logic               do_claim;
    logic               do_complete;
    logic [31:0]        claim_val;
    logic [5:0]         hw_next;

    assign hit  = ictrl_hit(addr, BASE);
    assign off  = addr[3:0];
    assign full = hit && (byteen == 4'b1111);

    int_ctrl_prio #(.N(NUM_SRC)) u_prio (
        .req   (pending & mask),
        .valid (win_valid),
        .id    (win_id)
    );

    assign claim_at    = hit && (off == ICTRL_CLAIM);
    assign do_claim    = claim_at && rd_en && (state == ICTRL_IDLE) && win_valid;
    assign do_complete = claim_at && full && (state == ICTRL_CLAIMED) && (wdata == 32'(claim_id));
    assign claim_val   = (state == ICTRL_IDLE && win_valid) ? 32'(win_id) : ICTRL_NONE;

    always_comb begin
        rdata = !hit                    ? 32'd0 :
                (off == ICTRL_PENDING)  ? 32'(pending) :
                (off == ICTRL_MASK)     ? 32'(mask) :
                (off == ICTRL_MODE)     ? 32'(mode) :
                (off == ICTRL_CLAIM)    ? claim_val : 32'd0;
    end

`ifdef INT_CTRL_EDGE_EN
    logic [NUM_SRC-1:0] irq_q;
    logic [NUM_SRC-1:0] claim_clr;

    always_comb begin
        claim_clr = '0;
        for (int i = 0; i < NUM_SRC; i++)
            claim_clr[i] = do_claim && (win_id == 4'(i));
    end

    // A rising edge is ORed in after the claim clear, so a new edge in the claim cycle survives.
    assign pending_next = (mode & ((pending & ~claim_clr) | (irq_i & ~irq_q))) | (~mode & irq_i);

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= '0;
            mode  <= '0;
        end else begin
            irq_q <= irq_i;
            if (full && off == ICTRL_MODE)
                mode <= wdata[NUM_SRC-1:0];
        end
    end
`else
    assign mode         = '0;
    assign pending_next = irq_i;
`endif

    always_comb begin
        hw_next           = hw_in;
        hw_next[OUT_LINE] = (state == ICTRL_IDLE) && |(pending & mask);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= '0;
            mask     <= '0;
            state    <= ICTRL_IDLE;
            claim_id <= 4'd0;
            HWInt    <= 6'd0;
        end else begin
            pending <= pending_next;
            HWInt   <= hw_next;
            if (full && off == ICTRL_MASK)
                mask <= wdata[NUM_SRC-1:0];
            if (do_claim) begin
                state    <= ICTRL_CLAIMED;
                claim_id <= win_id;
            end else if (do_complete) begin
                state <= ICTRL_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed and randomized self-checking bench for int_ctrl against a behavioural model
module tb_int_ctrl;

    localparam logic [31:0] BASE = 32'h0000_7F40;
`ifdef INT_CTRL_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [7:0]  irq_i;
    logic [5:0]  hw_in;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic        rd_en;
    logic [31:0] rdata;
    logic [5:0]  HWInt;

    int_ctrl #(.NUM_SRC(8), .BASE(BASE), .OUT_LINE(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .irq_i  (irq_i),
        .hw_in  (hw_in),
        .addr   (addr),
        .byteen (byteen),
        .wdata  (wdata),
        .rd_en  (rd_en),
        .rdata  (rdata),
        .HWInt  (HWInt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  cur_irq = '0;
    logic [5:0]  cur_hw = '0;
    logic        cur_rst = 1'b0;
    logic [31:0] last_rd;
    bit          armed = 1'b0;

    logic [7:0]  m_pend, m_mask, m_mode, m_prev;
    bit          m_claimed;
    int          m_cid;
    logic [5:0]  m_hw;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int winner();
        for (int i = 0; i < 8; i++)
            if (m_pend[i] && m_mask[i]) return i;
        return -1;
    endfunction

    task automatic tick(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd, input logic re);
        logic [7:0]  np, nmask, nmode;
        bit          nc, inw, fullw, clm;
        int          ncid, w;
        logic [5:0]  nhw;
        logic [31:0] er;
        addr = a; byteen = be; wdata = wd; rd_en = re;
        irq_i = cur_irq; hw_in = cur_hw; reset = cur_rst;
        #1;
        w   = winner();
        inw = (a[31:4] == BASE[31:4]) && (a[1:0] == 2'b00);
        er  = 32'd0;
        if (inw) begin
            if (a[3:0] == 4'h0) er = {24'd0, m_pend};
            if (a[3:0] == 4'h4) er = {24'd0, m_mask};
            if (a[3:0] == 4'h8) er = {24'd0, m_mode};
            if (a[3:0] == 4'hC) er = (!m_claimed && w >= 0) ? 32'(w) : 32'hFFFF_FFFF;
        end
        last_rd = rdata;
        if (armed) chk("rdata", rdata, er);
        fullw = inw && be == 4'hF;
        clm   = inw && a[3:0] == 4'hC && re && !m_claimed && w >= 0;
        for (int i = 0; i < 8; i++)
            np[i] = m_mode[i] ? ((m_pend[i] && !(clm && w == i)) || (cur_irq[i] && !m_prev[i])) : cur_irq[i];
        nmask = (fullw && a[3:0] == 4'h4) ? wd[7:0] : m_mask;
        nmode = (EDGE && fullw && a[3:0] == 4'h8) ? wd[7:0] : m_mode;
        nc = m_claimed;
        ncid = m_cid;
        if (clm) begin
            nc = 1'b1;
            ncid = w;
        end else if (m_claimed && fullw && a[3:0] == 4'hC && wd == 32'(m_cid)) begin
            nc = 1'b0;
        end
        nhw = cur_hw;
        nhw[2] = !m_claimed && |(m_pend & m_mask);
        @(posedge clk);
        #1;
        if (cur_rst) begin
            m_pend = '0; m_mask = '0; m_mode = '0; m_prev = '0;
            m_claimed = 1'b0; m_cid = 0; m_hw = '0;
        end else begin
            m_pend = np; m_mask = nmask; m_mode = nmode; m_prev = cur_irq;
            m_claimed = nc; m_cid = ncid; m_hw = nhw;
        end
        armed = 1'b1;
        chk("hwint", {26'd0, HWInt}, {26'd0, m_hw});
    endtask

    task automatic idle();
        tick(32'd0, 4'd0, 32'd0, 1'b0);
    endtask

    task automatic wr(input logic [3:0] o, input logic [31:0] d);
        tick(BASE + 32'(o), 4'hF, d, 1'b0);
    endtask

    task automatic rd(input logic [3:0] o);
        tick(BASE + 32'(o), 4'h0, 32'd0, 1'b1);
    endtask

    task automatic do_reset();
        cur_rst = 1'b1;
        idle();
        cur_rst = 1'b0;
    endtask

    initial begin
        reset = 1'b1; irq_i = '0; hw_in = '0; addr = '0; byteen = '0; wdata = '0; rd_en = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        rd(4'h0); chk("rst_pending", last_rd, 32'd0);
        rd(4'h4); chk("rst_mask", last_rd, 32'd0);
        rd(4'h8); chk("rst_mode", last_rd, 32'd0);
        rd(4'hC); chk("rst_claim", last_rd, 32'hFFFF_FFFF);
        chk("rst_hwint", {26'd0, HWInt}, 32'd0);

        wr(4'h4, 32'h0C);
        cur_irq = 8'h08;
        idle();
        idle(); chk("lvl_hw_up", {31'd0, HWInt[2]}, 32'd1);
        rd(4'hC); chk("claim3", last_rd, 32'd3);
        idle(); chk("claimed_hw_down", {31'd0, HWInt[2]}, 32'd0);
        wr(4'hC, 32'd3);
        idle(); chk("lvl_reassert", {31'd0, HWInt[2]}, 32'd1);

        do_reset();
        wr(4'h4, 32'hFF);
        cur_irq = 8'h22;
        idle();
        rd(4'hC); chk("prio_1", last_rd, 32'd1);
        cur_irq = 8'h20;
        wr(4'hC, 32'd1);
        rd(4'hC); chk("prio_5", last_rd, 32'd5);
        rd(4'hC); chk("claim_busy", last_rd, 32'hFFFF_FFFF);

`ifdef INT_CTRL_EDGE_EN
        do_reset();
        wr(4'h8, 32'h01);
        wr(4'h4, 32'h01);
        cur_irq = 8'h01; idle();
        cur_irq = 8'h00; idle(); idle();
        rd(4'h0); chk("edge_persist", last_rd, 32'h01);
        rd(4'hC); chk("edge_claim0", last_rd, 32'd0);
        rd(4'h0); chk("edge_cleared", last_rd, 32'h00);
        wr(4'hC, 32'd0);
        cur_irq = 8'h01; idle();
        cur_irq = 8'h00; idle();
        cur_irq = 8'h01; rd(4'hC); chk("edge_claim_again", last_rd, 32'd0);
        cur_irq = 8'h00; rd(4'h0); chk("edge_wins", last_rd, 32'h01);
`endif

        do_reset();
        wr(4'h4, 32'hFF);
        cur_irq = 8'h10;
        idle();
        rd(4'hC); chk("claim4", last_rd, 32'd4);
        wr(4'hC, 32'd2);
        rd(4'hC); chk("wrong_id", last_rd, 32'hFFFF_FFFF);
        tick(BASE + 32'hC, 4'b0011, 32'd4, 1'b0);
        rd(4'hC); chk("partial_wr", last_rd, 32'hFFFF_FFFF);
        wr(4'hC, 32'd4);
        rd(4'hC); chk("complete4", last_rd, 32'd4);
        do_reset();
        chk("rst_claimed_hw", {26'd0, HWInt}, 32'd0);
        rd(4'h0); chk("rst_claimed_pend", last_rd, 32'd0);
        rd(4'h4); chk("rst_claimed_mask", last_rd, 32'd0);
        rd(4'hC); chk("rst_claimed_claim", last_rd, 32'hFFFF_FFFF);

        cur_irq = 8'h00;
        cur_hw = 6'b100101;
        idle(); chk("passthru", {26'd0, HWInt}, 32'h21);
        cur_hw = 6'b000000;
        idle(); chk("passthru_off", {26'd0, HWInt}, 32'h00);

        for (int n = 0; n < 4000; n++) begin
            int          r;
            logic [31:0] a, wd;
            logic [3:0]  be;
            cur_rst = ($urandom_range(0, 299) == 0);
            cur_irq = cur_irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            cur_hw  = 6'($urandom);
            r = $urandom_range(0, 9);
            a = (r < 4) ? BASE + 32'(4 * r) :
                (r == 4) ? BASE + 32'($urandom_range(0, 15)) :
                (r == 5) ? $urandom : BASE + 32'hC;
            be = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            wd = $urandom_range(0, 1) ? 32'($urandom_range(0, 9)) : $urandom;
            if ($urandom_range(0, 2) != 0) be = 4'h0;
            tick(a, be, wd, 1'($urandom));
        end
        cur_rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
